// File: rtl/rtp_pkg.sv
// rtp_pkg: shared constants and types for the RTP game-controller packet parser.
//
// Holds the fixed frame layout (IPv4 20 bytes, UDP 8 bytes, RTP 12 bytes, payload
// 4 bytes), the byte offsets of every field the parser inspects, the protocol
// constants it checks against, the parser state enum and a small movement helper.
// Offsets are 6-bit so they compare directly against the parser byte counter.
package rtp_pkg;

  localparam int IP_HDR_BYTES  = 20;
  localparam int UDP_HDR_BYTES = 8;
  localparam int RTP_HDR_BYTES = 12;
  localparam int PAYLOAD_BYTES = 4;
  localparam int PKT_BYTES     = IP_HDR_BYTES + UDP_HDR_BYTES + RTP_HDR_BYTES + PAYLOAD_BYTES;

  // Segment start indices and index of the final byte of a well-formed packet.
  localparam logic [5:0] UDP_START = 6'(IP_HDR_BYTES);
  localparam logic [5:0] RTP_START = 6'(IP_HDR_BYTES + UDP_HDR_BYTES);
  localparam logic [5:0] PAY_START = 6'(IP_HDR_BYTES + UDP_HDR_BYTES + RTP_HDR_BYTES);
  localparam logic [5:0] LAST_IDX  = 6'(PKT_BYTES - 1);

  // Field offsets within the packet (first byte of each multi-byte field).
  localparam logic [5:0] OFF_IP_VER    = 6'd0;
  localparam logic [5:0] OFF_IP_LEN    = 6'd2;
  localparam logic [5:0] OFF_IP_PROTO  = 6'd9;
  localparam logic [5:0] OFF_IP_DST    = 6'd16;
  localparam logic [5:0] OFF_UDP_DPORT = UDP_START + 6'd2;
  localparam logic [5:0] OFF_UDP_LEN   = UDP_START + 6'd4;
  localparam logic [5:0] OFF_RTP_VER   = RTP_START;
  localparam logic [5:0] OFF_RTP_PT    = RTP_START + 6'd1;
  localparam logic [5:0] OFF_RTP_SEQ   = RTP_START + 6'd2;
  localparam logic [5:0] OFF_RTP_TS    = RTP_START + 6'd4;

  // Protocol constants.
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  IPV4_PROTO_UDP = 8'h11;
  localparam logic [1:0]  RTP_VERSION    = 2'd2;
  localparam logic [15:0] IPV4_TOTAL_LEN = 16'(PKT_BYTES);
  localparam logic [15:0] UDP_LEN        = 16'(UDP_HDR_BYTES + RTP_HDR_BYTES + PAYLOAD_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    IP_HDR,
    UDP_HDR,
    RTP_HDR,
    PAYLOAD,
    DRAIN
  } state_t;

  // Movement codes 0..4 are meaningful; 5..7 mark a corrupt controller frame.
  function automatic logic movementLegal(input logic [2:0] mv);
    return (mv <= 3'd4);
  endfunction

endpackage

// File: rtl/rtp_seq_checker.sv
// rtp_seq_checker: decides whether a new RTP sequence number may be accepted.
//
// Only built when RTP_SEQ_CHECK_EN is defined (the parser instantiates it only then).
// A packet is in order when nothing has been accepted since reset, or when the
// forward distance (seq - last) modulo 2^16 lies in 1..32767, i.e. it is newer
// than the last one and not a duplicate.
//
// Ports:
//   seq_i        new packet's sequence number
//   last_seq_i   sequence number of the last accepted packet
//   have_last_i  a packet has been accepted since reset
//   seq_ok_o     new packet is in order
`ifdef RTP_SEQ_CHECK_EN
module rtp_seq_checker (
  input  logic [15:0] seq_i,
  input  logic [15:0] last_seq_i,
  input  logic        have_last_i,
  output logic        seq_ok_o
);

  logic [15:0] seqDiff;

  // Forward distance wraps naturally in 16 bits; the top bit set means the
  // new number is behind (or more than half the space ahead).
  always_comb begin
    seqDiff  = seq_i - last_seq_i;
    seq_ok_o = !have_last_i || ((seqDiff != 16'd0) && !seqDiff[15]);
  end

endmodule
`endif

// File: rtl/rtp_packet_parser.sv
// rtp_packet_parser: byte-stream parser for 44-byte IPv4/UDP/RTP controller packets.
//
// Each packet carries four payload bytes, one per player: bits[6:4] movement,
// bits[2:0] shooting. The parser checks the IPv4, UDP and RTP header fields it
// cares about, captures RTP marker/sequence/timestamp, and on a clean packet
// updates all data outputs and pulses valid_out. A rejected packet pulses
// drop_out once, in the cycle after its last byte, and leaves outputs alone.
//
// Optional build macro: RTP_SEQ_CHECK_EN -- when defined, a packet is also
// rejected unless its sequence number is newer than the last accepted one
// (the first packet after reset is always in order).
//
// Parameters:
//   LOCAL_IP  required IPv4 destination address
//   DST_PORT  required UDP destination port
//   RTP_PT    required RTP payload type
// Ports:
//   clk_in            clock, rising edge
//   rst_in            synchronous active-high reset
//   data_in           packet byte, network order
//   data_valid_in     data_in valid this cycle
//   data_last_in      with data_valid_in: final byte of packet
//   pN_movement/_shooting  player N controls from last accepted packet
//   rtp_seq_out, rtp_timestamp_out, rtp_marker_out  RTP fields of last accepted packet
//   valid_out         one-cycle pulse: packet accepted
//   drop_out          one-cycle pulse: packet rejected
module rtp_packet_parser
  import rtp_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP = 32'h0A000002,
  parameter logic [15:0] DST_PORT = 16'hFFFF,
  parameter logic [6:0]  RTP_PT   = 7'h1F
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  data_in,
  input  logic        data_valid_in,
  input  logic        data_last_in,
  output logic [2:0]  p1_movement,
  output logic [2:0]  p2_movement,
  output logic [2:0]  p3_movement,
  output logic [2:0]  p4_movement,
  output logic [2:0]  p1_shooting,
  output logic [2:0]  p2_shooting,
  output logic [2:0]  p3_shooting,
  output logic [2:0]  p4_shooting,
  output logic [15:0] rtp_seq_out,
  output logic [31:0] rtp_timestamp_out,
  output logic        rtp_marker_out,
  output logic        valid_out,
  output logic        drop_out
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;

  // Header fields and first three payload bytes captured while the packet streams in.
  logic        markerCap_q, markerCap_d;
  logic [15:0] seqCap_q, seqCap_d;
  logic [31:0] tsCap_q, tsCap_d;
  logic [8:0]  payMv_q, payMv_d;
  logic [8:0]  paySh_q, paySh_d;

  // Visible outputs: player N lives at bits [3N-1:3N-3].
  logic [11:0] mv_q, mv_d;
  logic [11:0] sh_q, sh_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] ts_q, ts_d;
  logic        marker_q, marker_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;

  logic        byteOk;
  logic        seqOk;

`ifdef RTP_SEQ_CHECK_EN
  logic haveSeq_q;

  rtp_seq_checker u_seq_checker (
    .seq_i       (seqCap_q),
    .last_seq_i  (seq_q),
    .have_last_i (haveSeq_q),
    .seq_ok_o    (seqOk)
  );

  // Remembers whether any packet has been accepted since reset, so the very
  // first packet is never judged against the cleared sequence output.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      haveSeq_q <= 1'b0;
    end else if (valid_d) begin
      haveSeq_q <= 1'b1;
    end
  end
`else
  assign seqOk = 1'b1;
`endif

  // Per-byte field check, keyed on the byte's position in the packet. Bytes
  // whose position carries nothing we check are always fine.
  always_comb begin
    byteOk = 1'b1;
    case (cnt_q)
      OFF_IP_VER:            byteOk = (data_in == IPV4_VER_IHL);
      OFF_IP_LEN:            byteOk = (data_in == IPV4_TOTAL_LEN[15:8]);
      OFF_IP_LEN + 6'd1:     byteOk = (data_in == IPV4_TOTAL_LEN[7:0]);
      OFF_IP_PROTO:          byteOk = (data_in == IPV4_PROTO_UDP);
      OFF_IP_DST:            byteOk = (data_in == LOCAL_IP[31:24]);
      OFF_IP_DST + 6'd1:     byteOk = (data_in == LOCAL_IP[23:16]);
      OFF_IP_DST + 6'd2:     byteOk = (data_in == LOCAL_IP[15:8]);
      OFF_IP_DST + 6'd3:     byteOk = (data_in == LOCAL_IP[7:0]);
      OFF_UDP_DPORT:         byteOk = (data_in == DST_PORT[15:8]);
      OFF_UDP_DPORT + 6'd1:  byteOk = (data_in == DST_PORT[7:0]);
      OFF_UDP_LEN:           byteOk = (data_in == UDP_LEN[15:8]);
      OFF_UDP_LEN + 6'd1:    byteOk = (data_in == UDP_LEN[7:0]);
      OFF_RTP_VER:           byteOk = (data_in[7:6] == RTP_VERSION);
      OFF_RTP_PT:            byteOk = (data_in[6:0] == RTP_PT);
      PAY_START, PAY_START + 6'd1, PAY_START + 6'd2, LAST_IDX:
                             byteOk = movementLegal(data_in[6:4]);
      default:               byteOk = 1'b1;
    endcase
  end

  // Next-state logic. The byte counter is the packet position; the state only
  // distinguishes the header segments, and whether we are discarding the rest
  // of a bad packet (DRAIN). A premature last byte ends the packet on the spot,
  // while a failed check keeps swallowing bytes until the sender's last byte so
  // the next packet starts aligned.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    markerCap_d = markerCap_q;
    seqCap_d    = seqCap_q;
    tsCap_d     = tsCap_q;
    payMv_d     = payMv_q;
    paySh_d     = paySh_q;
    mv_d        = mv_q;
    sh_d        = sh_q;
    seq_d       = seq_q;
    ts_d        = ts_q;
    marker_d    = marker_q;
    valid_d     = 1'b0;
    drop_d      = 1'b0;

    if (data_valid_in) begin
      if (state_q == DRAIN) begin
        if (data_last_in) begin
          drop_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      end else begin
        case (cnt_q)
          OFF_RTP_PT:         markerCap_d       = data_in[7];
          OFF_RTP_SEQ:        seqCap_d[15:8]    = data_in;
          OFF_RTP_SEQ + 6'd1: seqCap_d[7:0]     = data_in;
          OFF_RTP_TS:         tsCap_d[31:24]    = data_in;
          OFF_RTP_TS + 6'd1:  tsCap_d[23:16]    = data_in;
          OFF_RTP_TS + 6'd2:  tsCap_d[15:8]     = data_in;
          OFF_RTP_TS + 6'd3:  tsCap_d[7:0]      = data_in;
          PAY_START: begin
            payMv_d[2:0] = data_in[6:4];
            paySh_d[2:0] = data_in[2:0];
          end
          PAY_START + 6'd1: begin
            payMv_d[5:3] = data_in[6:4];
            paySh_d[5:3] = data_in[2:0];
          end
          PAY_START + 6'd2: begin
            payMv_d[8:6] = data_in[6:4];
            paySh_d[8:6] = data_in[2:0];
          end
          default: ;
        endcase

        if (data_last_in && (cnt_q != LAST_IDX)) begin
          drop_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else if (cnt_q == LAST_IDX) begin
          cnt_d = 6'd0;
          if (!data_last_in) begin
            state_d = DRAIN;
          end else if (byteOk && seqOk) begin
            // Last payload byte goes straight to the outputs with the captured ones.
            mv_d     = {data_in[6:4], payMv_q};
            sh_d     = {data_in[2:0], paySh_q};
            seq_d    = seqCap_q;
            ts_d     = tsCap_q;
            marker_d = markerCap_q;
            valid_d  = 1'b1;
            state_d  = IDLE;
          end else begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (!byteOk) begin
          state_d = DRAIN;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_d < UDP_START) begin
            state_d = IP_HDR;
          end else if (cnt_d < RTP_START) begin
            state_d = UDP_HDR;
          end else if (cnt_d < PAY_START) begin
            state_d = RTP_HDR;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
    end
  end

  // State, captures and outputs; reset discards any partial packet silently.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      markerCap_q <= 1'b0;
      seqCap_q    <= 16'd0;
      tsCap_q     <= 32'd0;
      payMv_q     <= 9'd0;
      paySh_q     <= 9'd0;
      mv_q        <= 12'd0;
      sh_q        <= 12'd0;
      seq_q       <= 16'd0;
      ts_q        <= 32'd0;
      marker_q    <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      markerCap_q <= markerCap_d;
      seqCap_q    <= seqCap_d;
      tsCap_q     <= tsCap_d;
      payMv_q     <= payMv_d;
      paySh_q     <= paySh_d;
      mv_q        <= mv_d;
      sh_q        <= sh_d;
      seq_q       <= seq_d;
      ts_q        <= ts_d;
      marker_q    <= marker_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
    end
  end

  assign p1_movement       = mv_q[2:0];
  assign p2_movement       = mv_q[5:3];
  assign p3_movement       = mv_q[8:6];
  assign p4_movement       = mv_q[11:9];
  assign p1_shooting       = sh_q[2:0];
  assign p2_shooting       = sh_q[5:3];
  assign p3_shooting       = sh_q[8:6];
  assign p4_shooting       = sh_q[11:9];
  assign rtp_seq_out       = seq_q;
  assign rtp_timestamp_out = ts_q;
  assign rtp_marker_out    = marker_q;
  assign valid_out         = valid_q;
  assign drop_out          = drop_q;

endmodule

// File: tb/tb_rtp_packet_parser.sv
// tb_rtp_packet_parser: scoreboard bench for rtp_packet_parser.
//
// Stimulus builds 44-byte packets in a buffer, pushes the hand-computed expected
// response (accept with data, or drop with outputs unchanged) onto a queue, then
// streams the bytes. A monitor pops one entry for every valid_out/drop_out pulse.
// Honours RTP_SEQ_CHECK_EN for the expected outcome of a repeated sequence number.
module tb_rtp_packet_parser;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid_in = 1'b0;
  logic        data_last_in = 1'b0;
  logic [2:0]  p1_movement, p2_movement, p3_movement, p4_movement;
  logic [2:0]  p1_shooting, p2_shooting, p3_shooting, p4_shooting;
  logic [15:0] rtp_seq_out;
  logic [31:0] rtp_timestamp_out;
  logic        rtp_marker_out;
  logic        valid_out;
  logic        drop_out;

  typedef struct packed {
    logic        isAccept;
    logic [11:0] mv;
    logic [11:0] sh;
    logic [15:0] seq;
    logic [31:0] ts;
    logic        marker;
  } exp_t;

  exp_t       expQ[$];
  exp_t       lastOut;
  exp_t       monEvt;
  int         total = 0;
  int         bad = 0;
  logic [7:0] pkt [48];

  rtp_packet_parser dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .data_in           (data_in),
    .data_valid_in     (data_valid_in),
    .data_last_in      (data_last_in),
    .p1_movement       (p1_movement),
    .p2_movement       (p2_movement),
    .p3_movement       (p3_movement),
    .p4_movement       (p4_movement),
    .p1_shooting       (p1_shooting),
    .p2_shooting       (p2_shooting),
    .p3_shooting       (p3_shooting),
    .p4_shooting       (p4_shooting),
    .rtp_seq_out       (rtp_seq_out),
    .rtp_timestamp_out (rtp_timestamp_out),
    .rtp_marker_out    (rtp_marker_out),
    .valid_out         (valid_out),
    .drop_out          (drop_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fills the packet buffer with a legal frame; tests corrupt single bytes after.
  task automatic buildPacket(input logic [15:0] seq, input logic [31:0] ts, input logic marker,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 48; i++) pkt[i] = 8'h00;
    pkt[0]  = 8'h45; pkt[2]  = 8'h00; pkt[3]  = 8'h2C; pkt[8] = 8'h40; pkt[9] = 8'h11;
    pkt[10] = 8'hBE; pkt[11] = 8'hEF;
    pkt[12] = 8'hC0; pkt[13] = 8'hA8; pkt[14] = 8'h00; pkt[15] = 8'h01;
    pkt[16] = 8'h0A; pkt[17] = 8'h00; pkt[18] = 8'h00; pkt[19] = 8'h02;
    pkt[20] = 8'h12; pkt[21] = 8'h34; pkt[22] = 8'hFF; pkt[23] = 8'hFF;
    pkt[24] = 8'h00; pkt[25] = 8'h18; pkt[26] = 8'hAB; pkt[27] = 8'hCD;
    pkt[28] = 8'h80; pkt[29] = {marker, 7'h1F};
    pkt[30] = seq[15:8]; pkt[31] = seq[7:0];
    pkt[32] = ts[31:24]; pkt[33] = ts[23:16]; pkt[34] = ts[15:8]; pkt[35] = ts[7:0];
    pkt[36] = 8'hDE; pkt[37] = 8'hAD; pkt[38] = 8'hBE; pkt[39] = 8'hEF;
    pkt[40] = b0; pkt[41] = b1; pkt[42] = b2; pkt[43] = b3;
  endtask

  // Streams pkt[0..nBytes-1]; data_last_in rides on byte lastAt (-1: never).
  task automatic applyStimulus(input int nBytes, input int lastAt, input bit gaps);
    for (int i = 0; i < nBytes; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        repeat (g) begin
          @(posedge clk_in); #1;
          data_valid_in = 1'b0;
          data_in       = 8'($urandom);
          data_last_in  = 1'($urandom);
        end
      end
      @(posedge clk_in); #1;
      data_in       = pkt[i];
      data_valid_in = 1'b1;
      data_last_in  = (i == lastAt);
    end
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    data_last_in  = 1'b0;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic expectAccept(input logic [15:0] seq, input logic [31:0] ts, input logic marker,
                              input logic [11:0] mv, input logic [11:0] sh);
    exp_t e;
    e.isAccept = 1'b1; e.mv = mv; e.sh = sh; e.seq = seq; e.ts = ts; e.marker = marker;
    expQ.push_back(e);
    lastOut = e;
  endtask

  task automatic expectDrop();
    exp_t e;
    e = lastOut;
    e.isAccept = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " valid"}, 64'(valid_out), 64'd0);
    checkOutput({tag, " drop"}, 64'(drop_out), 64'd0);
    checkOutput({tag, " seq"}, 64'(rtp_seq_out), 64'd0);
    checkOutput({tag, " ts"}, 64'(rtp_timestamp_out), 64'd0);
    checkOutput({tag, " marker"}, 64'(rtp_marker_out), 64'd0);
    checkOutput({tag, " movement"}, 64'({p4_movement, p3_movement, p2_movement, p1_movement}), 64'd0);
    checkOutput({tag, " shooting"}, 64'({p4_shooting, p3_shooting, p2_shooting, p1_shooting}), 64'd0);
  endtask

  task automatic doReset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    data_valid_in = 1'b0;
    data_last_in  = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in  = 1'b0;
    lastOut = '0;
  endtask

  // Monitor: every pulse consumes one scoreboard entry and checks all outputs.
  always @(negedge clk_in) begin
    if (!rst_in && (valid_out || drop_out)) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected pulse: got valid=%0b drop=%0b expected none", valid_out, drop_out);
      end else begin
        monEvt = expQ.pop_front();
        checkOutput("pulse kind", 64'({valid_out, drop_out}), 64'({monEvt.isAccept, ~monEvt.isAccept}));
        checkOutput("movement", 64'({p4_movement, p3_movement, p2_movement, p1_movement}), 64'(monEvt.mv));
        checkOutput("shooting", 64'({p4_shooting, p3_shooting, p2_shooting, p1_shooting}), 64'(monEvt.sh));
        checkOutput("seq", 64'(rtp_seq_out), 64'(monEvt.seq));
        checkOutput("timestamp", 64'(rtp_timestamp_out), 64'(monEvt.ts));
        checkOutput("marker", 64'(rtp_marker_out), 64'(monEvt.marker));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lastOut = '0;
    doReset();
    checkResetState("reset");

    // Legal packet: p1=1/2, p2=3/4, p3=4/0, p4=0/7.
    buildPacket(16'h0100, 32'h11223344, 1'b1, 8'h12, 8'h34, 8'h40, 8'h07);
    expectAccept(16'h0100, 32'h11223344, 1'b1, {3'd0, 3'd4, 3'd3, 3'd1}, {3'd7, 3'd0, 3'd4, 3'd2});
    applyStimulus(44, 43, 1'b0);

    // Protocol TCP.
    buildPacket(16'h0101, 32'h55667788, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    pkt[9] = 8'h06;
    expectDrop();
    applyStimulus(44, 43, 1'b0);

    // Truncated at byte 30, then a legal packet.
    buildPacket(16'h0101, 32'h55667788, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    expectDrop();
    applyStimulus(31, 30, 1'b0);
    expectAccept(16'h0101, 32'h55667788, 1'b0, {3'd0, 3'd4, 3'd3, 3'd1}, {3'd7, 3'd0, 3'd4, 3'd2});
    applyStimulus(44, 43, 1'b0);

    // Movement 5 in payload byte 2, then movement 4 everywhere legal.
    buildPacket(16'h0102, 32'h0000ABCD, 1'b1, 8'h12, 8'h34, 8'h50, 8'h07);
    expectDrop();
    applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0102, 32'h0000ABCD, 1'b1, 8'h8B, 8'h2E, 8'h40, 8'hC5);
    expectAccept(16'h0102, 32'h0000ABCD, 1'b1, {3'd4, 3'd4, 3'd2, 3'd0}, {3'd5, 3'd0, 3'd6, 3'd3});
    applyStimulus(44, 43, 1'b0);

    // Payload byte 3 without last: drained until the late last byte.
    buildPacket(16'h0103, 32'h01010101, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    expectDrop();
    applyStimulus(46, 45, 1'b0);

    // Single-field corruptions.
    buildPacket(16'h0103, 32'h01010101, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    pkt[19] = 8'h03;
    expectDrop(); applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0103, 32'h01010101, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    pkt[23] = 8'hFE;
    expectDrop(); applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0103, 32'h01010101, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    pkt[28] = 8'h40;
    expectDrop(); applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0103, 32'h01010101, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    pkt[29] = 8'h1E;
    expectDrop(); applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0103, 32'h01010101, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    pkt[25] = 8'h19;
    expectDrop(); applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0103, 32'h01010101, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    pkt[0] = 8'h46;
    expectDrop(); applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0103, 32'h01010101, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    pkt[3] = 8'h2D;
    expectDrop(); applyStimulus(44, 43, 1'b0);

    // Legal packet with random valid gaps: p1=7? no -> 8'h31: mv3 sh1, 8'h02: mv0 sh2.
    buildPacket(16'h0103, 32'hCAFEF00D, 1'b1, 8'h31, 8'h02, 8'h13, 8'h44);
    expectAccept(16'h0103, 32'hCAFEF00D, 1'b1, {3'd4, 3'd1, 3'd0, 3'd3}, {3'd4, 3'd3, 3'd2, 3'd1});
    applyStimulus(44, 43, 1'b1);

    // Sequence wrap after reset.
    doReset();
    checkResetState("reset2");
    buildPacket(16'hFFFF, 32'h00000010, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    expectAccept(16'hFFFF, 32'h00000010, 1'b0, {3'd0, 3'd4, 3'd3, 3'd1}, {3'd7, 3'd0, 3'd4, 3'd2});
    applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0000, 32'h00000020, 1'b1, 8'h12, 8'h34, 8'h40, 8'h07);
    expectAccept(16'h0000, 32'h00000020, 1'b1, {3'd0, 3'd4, 3'd3, 3'd1}, {3'd7, 3'd0, 3'd4, 3'd2});
    applyStimulus(44, 43, 1'b0);
    buildPacket(16'h0000, 32'h00000030, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
`ifdef RTP_SEQ_CHECK_EN
    expectDrop();
`else
    expectAccept(16'h0000, 32'h00000030, 1'b0, {3'd0, 3'd4, 3'd3, 3'd1}, {3'd7, 3'd0, 3'd4, 3'd2});
`endif
    applyStimulus(44, 43, 1'b0);

    // Reset after 15 bytes, then a gapped legal packet.
    buildPacket(16'h7000, 32'h0BADBEEF, 1'b0, 8'h12, 8'h34, 8'h40, 8'h07);
    applyStimulus(15, -1, 1'b0);
    doReset();
    checkResetState("reset3");
    buildPacket(16'h5555, 32'h12345678, 1'b1, 8'h40, 8'h07, 8'h12, 8'h34);
    expectAccept(16'h5555, 32'h12345678, 1'b1, {3'd3, 3'd1, 3'd0, 3'd4}, {3'd4, 3'd2, 3'd7, 3'd0});
    applyStimulus(44, 43, 1'b1);

    for (int w = 0; w < 50 && expQ.size() != 0; w++) @(posedge clk_in);
    repeat (5) @(posedge clk_in);
    checkOutput("scoreboard empty", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
